// File: rtl/clk_div_multi_if.sv
// Configuration port for clk_div_multi: one valid/ready request carrying {channel, divisor}.
interface clk_div_multi_if #(
    parameter int unsigned N_CH  = 2,
    parameter int unsigned DIV_W = 16
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;

    modport master (output cfg_valid, output cfg_ch, output cfg_div, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_ch, input cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider with registered square wave and tick per channel.
// Define CLKDIV_SYNC_EN to add the sync input that phase-aligns all channels.
module clk_div_multi #(
    parameter int unsigned N_CH        = 2,
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic [N_CH-1:0]     en,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync,
`endif
    clk_div_multi_if.slave      cfg,
    output logic [N_CH-1:0]     clk_out,
    output logic [N_CH-1:0]     tick
);
    localparam int unsigned CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic [DIV_W-1:0] ctr_q [N_CH];
    logic [DIV_W-1:0] ctr_d [N_CH];
    logic [DIV_W-1:0] div_q [N_CH];
    logic [DIV_W-1:0] div_d [N_CH];
    logic [N_CH-1:0]  clk_out_q, clk_out_d;
    logic [N_CH-1:0]  tick_q, tick_d;
    logic             pend_q, pend_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;

    logic             sync_hit;
    logic             accept;
    logic             apply_hit;
    logic             wrap;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] ctr_nxt;

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = sync;
`else
    assign sync_hit = 1'b0;
`endif

    // Ready comes straight from the slot flop, so no comb path from cfg_* to cfg_ready.
    assign cfg.cfg_ready = ~pend_q;
    assign accept        = cfg.cfg_valid & ~pend_q;

    always_comb begin
        ctr_d      = ctr_q;
        div_d      = div_q;
        clk_out_d  = clk_out_q;
        tick_d     = '0;
        pend_d     = pend_q;
        pend_ch_d  = pend_ch_q;
        pend_div_d = pend_div_q;
        period     = '0;
        ctr_nxt    = '0;
        wrap       = 1'b0;
        apply_hit  = 1'b0;

        for (int unsigned i = 0; i < N_CH; i++) begin
            period    = (div_q[i] == '0) ? DIV_W'(1) : div_q[i];
            wrap      = (ctr_q[i] == period - DIV_W'(1));
            apply_hit = pend_q && (pend_ch_q == CH_W'(i));

            if (sync_hit) begin
                ctr_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                if (apply_hit) begin
                    div_d[i] = pend_div_q;
                    pend_d   = 1'b0;
                end
            end else if (en[i]) begin
                ctr_nxt      = wrap ? '0 : ctr_q[i] + DIV_W'(1);
                ctr_d[i]     = ctr_nxt;
                tick_d[i]    = wrap;
                clk_out_d[i] = (ctr_nxt >= period - (period >> 1));
                // Retune only at a period boundary so the current period completes intact.
                if (apply_hit && wrap) begin
                    div_d[i] = pend_div_q;
                    pend_d   = 1'b0;
                end
            end else if (apply_hit) begin
                div_d[i]     = pend_div_q;
                ctr_d[i]     = '0;
                clk_out_d[i] = 1'b0;
                pend_d       = 1'b0;
            end
        end

        // Out-of-range channel requests complete the handshake but never occupy the slot.
        if (accept && (32'(cfg.cfg_ch) < N_CH)) begin
            pend_d     = 1'b1;
            pend_ch_d  = cfg.cfg_ch;
            pend_div_d = cfg.cfg_div;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                ctr_q[i] <= '0;
                div_q[i] <= DIV_W'(DEFAULT_DIV);
            end
            clk_out_q  <= '0;
            tick_q     <= '0;
            pend_q     <= 1'b0;
            pend_ch_q  <= '0;
            pend_div_q <= '0;
        end else begin
            ctr_q      <= ctr_d;
            div_q      <= div_d;
            clk_out_q  <= clk_out_d;
            tick_q     <= tick_d;
            pend_q     <= pend_d;
            pend_ch_q  <= pend_ch_d;
            pend_div_q <= pend_div_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi (3 channels so an out-of-range cfg_ch is expressible).
module tb_clk_div_multi;
    localparam int unsigned N_CH  = 3;
    localparam int unsigned DIV_W = 16;

    logic            clk_in = 1'b0;
    logic            rst;
    logic [N_CH-1:0] en;
    logic [N_CH-1:0] clk_out;
    logic [N_CH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
    logic            sync;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    clk_div_multi_if #(.N_CH(N_CH), .DIV_W(DIV_W)) cfg_if ();

    clk_div_multi #(.N_CH(N_CH), .DIV_W(DIV_W), .DEFAULT_DIV(4)) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
`ifdef CLKDIV_SYNC_EN
        .sync    (sync),
`endif
        .cfg     (cfg_if.slave),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input logic [N_CH-1:0] en_val);
        rst              = 1'b1;
        en               = '0;
        cfg_if.cfg_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        en  = en_val;
    endtask

    // One-edge request; caller ensures cfg_ready is high beforehand.
    task automatic cfg_send(input logic [1:0] ch, input logic [15:0] div);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = ch;
        cfg_if.cfg_div   = div;
        step();
        cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        en               = '0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_ch    = '0;
        cfg_if.cfg_div   = '0;
`ifdef CLKDIV_SYNC_EN
        sync = 1'b0;
`endif

        // Reset state and default divide-by-4 on all channels
        step();
        step();
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_ready", 32'(cfg_if.cfg_ready), 1);
        rst = 1'b0;
        en  = 3'b111;
        for (int n = 1; n <= 12; n++) begin
            step();
            check("def_clk_out", 32'(clk_out), ((n % 4) >= 2) ? 32'h7 : 32'h0);
            check("def_tick", 32'(tick), ((n % 4) == 0) ? 32'h7 : 32'h0);
        end

        // Divisors 3 (ch0) and 1 (ch1), loaded while disabled
        do_reset(3'b000);
        cfg_send(2'd0, 16'd3);
        check("d3_ready_busy", 32'(cfg_if.cfg_ready), 0);
        step();
        check("d3_ready_free", 32'(cfg_if.cfg_ready), 1);
        cfg_send(2'd1, 16'd1);
        step();
        en = 3'b011;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("d3_clk_out", 32'(clk_out[0]), ((k % 3) == 2) ? 1 : 0);
            check("d3_tick", 32'(tick[0]), ((k % 3) == 0) ? 1 : 0);
            check("d1_clk_out", 32'(clk_out[1]), 0);
            check("d1_tick", 32'(tick[1]), 1);
        end

        // Retune ch0 from 4 to 6 accepted at ctr=1
        do_reset(3'b111);
        step();
        cfg_send(2'd0, 16'd6);
        check("rt_ready_c2", 32'(cfg_if.cfg_ready), 0);
        check("rt_clk_c2", 32'(clk_out[0]), 1);
        step();
        check("rt_ready_c3", 32'(cfg_if.cfg_ready), 0);
        check("rt_tick_c3", 32'(tick[0]), 0);
        step();
        check("rt_tick_apply", 32'(tick[0]), 1);
        check("rt_clk_apply", 32'(clk_out[0]), 0);
        check("rt_ready_apply", 32'(cfg_if.cfg_ready), 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("rt_clk_out", 32'(clk_out[0]), ((k % 6) >= 3) ? 1 : 0);
            check("rt_tick", 32'(tick[0]), ((k % 6) == 0) ? 1 : 0);
        end

        // Disabled apply on ch1, then out-of-range channel
        do_reset(3'b111);
        step();
        step();
        step();
        check("dis_clk_c3", 32'(clk_out[1]), 1);
        en = 3'b101;
        step();
        check("dis_hold_clk", 32'(clk_out[1]), 1);
        check("dis_hold_tick", 32'(tick[1]), 0);
        cfg_send(2'd1, 16'd5);
        check("dis_ready_busy", 32'(cfg_if.cfg_ready), 0);
        check("dis_clk_pend", 32'(clk_out[1]), 1);
        step();
        check("dis_clk_apply", 32'(clk_out[1]), 0);
        check("dis_ready_free", 32'(cfg_if.cfg_ready), 1);
        en = 3'b111;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("dis_tick", 32'(tick[1]), (k == 5) ? 1 : 0);
            check("dis_clk_out", 32'(clk_out[1]), (k >= 3 && k <= 4) ? 1 : 0);
        end
        cfg_send(2'd3, 16'd7);
        check("oor_ready", 32'(cfg_if.cfg_ready), 1);
        for (int k = 7; k <= 11; k++) begin
            step();
            check("oor_tick", 32'(tick[1]), ((k % 5) == 0) ? 1 : 0);
        end

        // Reset with a request pending
        do_reset(3'b111);
        step();
        step();
        cfg_send(2'd0, 16'd9);
        check("mr_ready_busy", 32'(cfg_if.cfg_ready), 0);
        rst = 1'b1;
        step();
        check("mr_ready", 32'(cfg_if.cfg_ready), 1);
        check("mr_clk_out", 32'(clk_out), 0);
        check("mr_tick", 32'(tick), 0);
        rst = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            check("mr_def_clk", 32'(clk_out[0]), ((n % 4) >= 2) ? 1 : 0);
            check("mr_def_tick", 32'(tick[0]), ((n % 4) == 0) ? 1 : 0);
        end

`ifdef CLKDIV_SYNC_EN
        // Sync aligns div-4 and div-6 channels
        do_reset(3'b000);
        cfg_send(2'd1, 16'd6);
        step();
        en = 3'b111;
        for (int k = 0; k < 5; k++) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check("sy_clk_out", 32'(clk_out), 0);
        check("sy_tick", 32'(tick), 0);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("sy_tick0", 32'(tick[0]), ((k % 4) == 0) ? 1 : 0);
            check("sy_tick1", 32'(tick[1]), ((k % 6) == 0) ? 1 : 0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
